// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit for the execute stage.
//
// Multiplies with a radix-2 shift-add engine and divides with a restoring
// divider, one bit per cycle, on operand magnitudes. The sign is applied in a
// final FIX cycle. Divide-by-zero and signed overflow bypass the engine and
// complete in the cycle after accept.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   in_valid       operation request
//   in_ready       unit can accept a request (IDLE only)
//   op             000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                  100 DIV, 101 DIVU, 110 REM, 111 REMU
//   operand1       rs1 (multiplicand / dividend)
//   operand2       rs2 (multiplier / divisor)
//   kill           abort any in-flight operation (pipeline flush)
//   out_valid      result available
//   out_ready      consumer accepts result
//   result         operation result
//   result_is_zero 1 when result == 0

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            result_is_zero
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   acc_r;   // product high half / partial remainder
    logic [XLEN-1:0]   low_r;   // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0]   opb_r;   // multiplicand / divisor magnitude
    logic              neg_r;   // final result must be negated
    logic [CNT_W-1:0]  count_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [XLEN-1:0]   result_r;
    logic              result_is_zero_r;

    // Magnitude of a value, treating it as two's complement only when signed.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        logic [XLEN-1:0] r;
        if (is_signed && v[XLEN-1]) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic              op1_signed_s;
    logic              op2_signed_s;
    logic              sign1_s;
    logic              sign2_s;
    logic              neg_s;
    logic              is_div_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic [XLEN-1:0]   abs1_s;
    logic [XLEN-1:0]   abs2_s;
    logic [XLEN-1:0]   fast_res_s;

    // Accept-time decode: operand signedness, magnitudes, sign of result, fast path.
    always_comb begin
        op1_signed_s = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
        op2_signed_s = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sign1_s      = op1_signed_s & operand1[XLEN-1];
        sign2_s      = op2_signed_s & operand2[XLEN-1];
        is_div_s     = op[2];
        // Remainder follows the dividend; product and quotient follow the XOR.
        if (op == OP_REM) begin
            neg_s = sign1_s;
        end else begin
            neg_s = sign1_s ^ sign2_s;
        end
        abs1_s     = abs_val(operand1, op1_signed_s);
        abs2_s     = abs_val(operand2, op2_signed_s);
        div_zero_s = is_div_s && (operand2 == {XLEN{1'b0}});
        div_ovf_s  = is_div_s && !op[0] && (operand1 == INT_MIN) && (operand2 == {XLEN{1'b1}});
        if (div_zero_s) begin
            fast_res_s = op[1] ? operand1 : {XLEN{1'b1}};
        end else begin
            fast_res_s = op[1] ? {XLEN{1'b0}} : operand1;
        end
    end

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN:0]     div_diff_s;

    // One iteration of the shift-add multiplier and the restoring divider.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (low_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r, low_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
    end

    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   fix_res_s;

    // Sign correction and output selection for the FIX cycle.
    always_comb begin
        prod_fix_s = neg_r ? -{acc_r, low_r} : {acc_r, low_r};
        quo_fix_s  = neg_r ? -low_r : low_r;
        rem_fix_s  = neg_r ? -acc_r : acc_r;
        fix_res_s  = {XLEN{1'b0}};
        case (op_r)
            OP_MUL:                       fix_res_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_s = quo_fix_s;
            OP_REM, OP_REMU:              fix_res_s = rem_fix_s;
            default:                      fix_res_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM and datapath registers; rst outranks kill, kill outranks everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            op_r             <= 3'b000;
            acc_r            <= {XLEN{1'b0}};
            low_r            <= {XLEN{1'b0}};
            opb_r            <= {XLEN{1'b0}};
            neg_r            <= 1'b0;
            count_r          <= {CNT_W{1'b0}};
            in_ready_r       <= 1'b1;
            out_valid_r      <= 1'b0;
            result_r         <= {XLEN{1'b0}};
            result_is_zero_r <= 1'b1;
        end else if (kill) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r       <= op;
                        neg_r      <= neg_s;
                        acc_r      <= {XLEN{1'b0}};
                        in_ready_r <= 1'b0;
                        // Divider shifts the dividend out of low_r; multiplier shifts the multiplier.
                        if (is_div_s) begin
                            low_r <= abs1_s;
                            opb_r <= abs2_s;
                        end else begin
                            low_r <= abs2_s;
                            opb_r <= abs1_s;
                        end
                        if (div_zero_s || div_ovf_s) begin
                            result_r         <= fast_res_s;
                            result_is_zero_r <= (fast_res_s == {XLEN{1'b0}});
                            out_valid_r      <= 1'b1;
                            count_r          <= {CNT_W{1'b0}};
                            state_r          <= DONE;
                        end else begin
                            count_r <= CNT_W'(XLEN);
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_r[2]) begin
                        // Restore (keep the shifted value) when the trial subtraction borrows.
                        if (div_diff_s[XLEN]) begin
                            acc_r <= div_shift_s[XLEN-1:0];
                            low_r <= {low_r[XLEN-2:0], 1'b0};
                        end else begin
                            acc_r <= div_diff_s[XLEN-1:0];
                            low_r <= {low_r[XLEN-2:0], 1'b1};
                        end
                    end else begin
                        acc_r <= mul_sum_s[XLEN:1];
                        low_r <= {mul_sum_s[0], low_r[XLEN-1:1]};
                    end
                    count_r <= count_r - CNT_W'(1'b1);
                    if (count_r == CNT_W'(1'b1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    result_r         <= fix_res_s;
                    result_is_zero_r <= (fix_res_s == {XLEN{1'b0}});
                    out_valid_r      <= 1'b1;
                    state_r          <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign result         = result_r;
    assign result_is_zero = result_is_zero_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed RV32M cases with
// literal expectations, randomized operations with backpressure and kills,
// and a cycle-by-cycle comparison against a behavioural reference model.

module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        result_is_zero;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: idle / busy with a latency countdown / done.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_res  = 32'h0;
    logic [31:0] m_pend = 32'h0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .operand1       (operand1),
        .operand2       (operand2),
        .kill           (kill),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .result_is_zero (result_is_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M result computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'h0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) p = 64'hFFFF_FFFF_FFFF_FFFF;
                else if (ovf)   p = ua;
                else            p = sa / sb;
            end
            3'd5: begin
                if (b == 32'h0) p = 64'hFFFF_FFFF_FFFF_FFFF;
                else            p = ua / ub;
            end
            3'd6: begin
                if (b == 32'h0) p = ua;
                else if (ovf)   p = 64'h0;
                else            p = sa % sb;
            end
            default: begin
                if (b == 32'h0) p = ua;
                else            p = ua % ub;
            end
        endcase
        return p[31:0];
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'h0) || (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    // Operand picker biased toward the interesting corners.
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = 32'h0;
        end else if (kill) begin
            m_busy = 1'b0; m_done = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_res = m_pend;
            end
        end else if (in_valid) begin
            m_pend = ref_res(op, operand1, operand2);
            if (is_fast(op, operand1, operand2)) begin
                m_done = 1'b1; m_res = m_pend;
            end else begin
                m_busy = 1'b1; m_cnt = LAT - 1;
            end
        end
    endtask

    task automatic check_all();
        chk1("in_ready", in_ready, !m_busy && !m_done);
        chk1("out_valid", out_valid, m_done);
        chk("result", result, m_res);
        chk1("result_is_zero", result_is_zero, m_res == 32'h0);
    endtask

    // One clock: model sees the same inputs as the DUT, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 100) begin step(); w++; end
        chk1("pre_accept_in_ready", in_ready, 1'b1);
        op = o; operand1 = a; operand2 = b; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; op = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin step(); lat++; end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("done_result", result, exp);
        chk1("done_zero", result_is_zero, exp == 32'h0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            step();
            chk("held_result", result, exp);
            chk1("held_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("post_in_ready", in_ready, 1'b1);
        chk1("post_out_valid", out_valid, 1'b0);
    endtask

    // Abort a DIVU in its 10th CALC cycle with kill or rst, then run DIVU 9/3.
    task automatic abort_test(input bit use_rst);
        op = 3'd5; operand1 = $urandom; operand2 = 32'h7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        if (use_rst) rst = 1'b1;
        else         kill = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        if (use_rst) chk("rst_result", result, 32'h0);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, LAT, 0);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        op = 3'd0; operand1 = 32'h0; operand2 = 32'h0;
        step(); step();
        chk1("reset_in_ready", in_ready, 1'b1);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", result, 32'h0);
        chk1("reset_zero", result_is_zero, 1'b1);
        rst = 1'b0;
        step();

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, 0);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT, 0);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 0);
        run_op(3'd2, 32'hFFFF_FFFF,  32'h2,         32'hFFFF_FFFF, LAT, 0);
        run_op(3'd4, 32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFD, LAT, 0);
        run_op(3'd6, 32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFF, LAT, 0);
        run_op(3'd5, 32'hFFFF_FFFF,  32'h2,         32'h7FFF_FFFF, LAT, 0);
        run_op(3'd7, 32'd100,        32'd7,         32'd2,         LAT, 0);
        run_op(3'd4, 32'd5,          32'h0,         32'hFFFF_FFFF, 1,   0);
        run_op(3'd7, 32'd5,          32'h0,         32'd5,         1,   0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,   0);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1,   0);
        run_op(3'd0, 32'd6,          32'd7,         32'd42,        LAT, 10);

        abort_test(1'b0);
        abort_test(1'b1);

        for (int n = 0; n < 120; n++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if ($urandom_range(0, 9) == 0) begin
                op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
                step();
                in_valid = 1'b0;
                repeat ($urandom_range(0, 36)) step();
                kill = 1'b1;
                step();
                kill = 1'b0;
            end else begin
                run_op(o, a, b, ref_res(o, a, b), is_fast(o, a, b) ? 1 : LAT, $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
